aes_mcol_seq: RTL
=================

Name: aes_mcol_seq

Overview:
- Iterative, handshaked forward MixColumns unit for the AES encrypt datapath; the inverse of the decrypt-side InvMixColumns stage.
- Accepts one 4*Nb-byte state and multiplies each column by the circulant matrix {02,03,01,01}. It processes one column per clock.
- GF(2^8) products are formed from the shared generator-3 EXP/LN tables, with the same table arithmetic as the decrypt-side column mixer.

Parameters:
- Nb, 4, number of 32-bit columns in the state (state = 4*Nb bytes, byte 4*i+r = row r of column i).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  State_in is valid.
- in_ready  output  1  block can accept a new state.
- State_in  input  8 x 4*Nb  input state bytes.
- EXP3  input  8 x 256  antilog table, base 03.
- LN3  input  8 x 256  log table, base 03.
- out_valid  output  1  State_out holds a finished result.
- out_ready  input  1  consumer accepts State_out.
- State_out  output  8 x 4*Nb  mixed state, registered.
- busy  output  1  high while columns are being processed (state BUSY).

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, column counter=0, internal state buffer cleared to 0.
  - State_out all bytes 0, out_valid=0, busy=0, in_ready=1 from the following cycle.
  - Reset mid-operation discards the state in flight; no partial output ever becomes valid.
- FSM states:
  - IDLE: in_ready=1. If in_valid=1, capture State_in into the buffer, clear the counter and go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, column c=counter is replaced in the buffer by its mixed value and the counter increments. When c==Nb-1, copy the full mixed buffer to State_out, set out_valid=1 and go to DONE.
  - DONE: out_valid=1, in_ready=0. State_out is held stable until out_ready=1. On that edge out_valid is cleared and the FSM goes to IDLE.
- Latency: acceptance at edge T gives out_valid=1 after edge T+Nb (Nb=4: 4 cycles). Throughput is at most one state per Nb+2 cycles.
- No combinational path from in_valid/State_in to any output. in_ready is a decode of the registered state only.
- in_valid while not IDLE is ignored; the upstream producer holds its data.
- out_ready while not in DONE has no effect.
- Column math, with s0..s3 the input column and {02}x written as gmul(02,x):
  - r0 = 02·s0 ^ 03·s1 ^ s2 ^ s3
  - r1 = s0 ^ 02·s1 ^ 03·s2 ^ s3
  - r2 = s0 ^ s1 ^ 02·s2 ^ 03·s3
  - r3 = 03·s0 ^ s1 ^ s2 ^ 02·s3
- gmul(a,b):
  - Returns 0 if either operand is 0.
  - Otherwise returns EXP3[(LN3[a]+LN3[b]) mod 255], with the sum computed at 9 bits before the modulo.
  - Multiplication by 01 is pass-through and needs no table lookup.
- Only one column's multipliers are instantiated (8 gmul); the counter selects the column.
- State_out changes only on the BUSY→DONE edge or at reset.

Test Plan:
- FIPS-197 column: State_in column 0 = db 13 53 45, other columns f2 0a 22 5c / 01 01 01 01 / c6 c6 c6 c6.
  - Required State_out: 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6.
  - out_valid rises exactly 4 cycles after the accepting edge.
- Round-1 AES state: columns d4 bf 5d 30 / e0 b4 52 ae / b8 41 11 f1 / 1e 27 98 e5 -> 04 66 81 e5 / e0 cb 19 9a / 48 f8 d3 7a / 28 06 26 4c.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - State_out stays stable, in_ready=0, and a new in_valid is ignored.
  - Raise out_ready: next cycle in_ready=1 and the second state is accepted.
- Zero and odd bytes: all-zero state -> all-zero output. Column d4 d4 d4 d5 -> d5 d5 d7 d6; column 2d 26 31 4c -> 4d 7e bd f8.
- Reset in BUSY: assert rst 2 cycles after acceptance.
  - out_valid never rises, State_out=0, in_ready=1 after reset.
  - The next vector produces a correct result.
- Back-to-back traffic: drive 3 states with in_valid held high and out_ready=1.
  - Each result is correct and in order.
  - Results appear at 6-cycle spacing (Nb+2).

Source files
------------

// File: rtl/aes_mcol_seq.sv
// Iterative forward MixColumns: one column per clock through a
// single set of EXP3/LN3 table multipliers, valid/ready on both sides.
module aes_mcol_seq #(
  parameter int Nb = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*Nb-1:0][7:0]  State_in,
  input  logic [255:0][7:0]     EXP3,
  input  logic [255:0][7:0]     LN3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*Nb-1:0][7:0]  State_out,
  output logic                  busy
);

  localparam int CW = (Nb > 1) ? $clog2(Nb) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [Nb-1:0][3:0][7:0] sbuf;
  logic [Nb-1:0][3:0][7:0] mix_buf;
  logic [3:0][7:0]         col;
  logic [3:0][7:0]         m2;
  logic [3:0][7:0]         m3;
  logic [3:0][7:0]         res;

  // Log-domain product; k is always a nonzero constant here.
  function automatic logic [7:0] gmul(
    input logic [7:0]          k,
    input logic [7:0]          x,
    input logic [255:0][7:0]   e,
    input logic [255:0][7:0]   l
  );
    logic [8:0] s;
    s = {1'b0, l[k]} + {1'b0, l[x]};
    if (s >= 9'd255) s = s - 9'd255;
    return (x == 8'h00) ? 8'h00 : e[s[7:0]];
  endfunction

  always_comb begin
    col = sbuf[cnt];
    m2  = '0;
    m3  = '0;
    for (int r = 0; r < 4; r++) begin
      m2[r] = gmul(8'h02, col[r], EXP3, LN3);
      m3[r] = gmul(8'h03, col[r], EXP3, LN3);
    end
    res[0] = m2[0] ^ m3[1] ^ col[2] ^ col[3];
    res[1] = col[0] ^ m2[1] ^ m3[2] ^ col[3];
    res[2] = col[0] ^ col[1] ^ m2[2] ^ m3[3];
    res[3] = m3[0] ^ col[1] ^ col[2] ^ m2[3];
    mix_buf      = sbuf;
    mix_buf[cnt] = res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sbuf      <= '0;
      State_out <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sbuf     <= State_in;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          sbuf <= mix_buf;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(Nb - 1)) begin
            State_out <= mix_buf;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
